// File: rtl/spike_codec_pkg.sv
// Shared types and constants for the spike codec blocks (neuron and ISI decoder).
package spike_codec_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } isi_state_e;

  localparam int CNT_W_DEF = 16;

  // Q4.16 membrane format used by the neuron: 20-bit signed, 16 fractional bits
  localparam int Q_W    = 20;
  localparam int Q_FRAC = 16;
  typedef logic signed [Q_W-1:0] q4_16_t;

endpackage

// File: rtl/isi_fifo.sv
// Synchronous FIFO for ISI entries; a push into a full FIFO is accepted only when a pop frees a slot that cycle.
module isi_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push, w_do_pop;

  assign o_full     = (r_count == FULL_CNT);
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_do_pop   = i_pop & ~o_empty;
  assign w_do_push  = i_push & (~o_full | w_do_pop);
  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spike_isi_decoder.sv
// Decodes a spike level into inter-spike intervals (clk cycles) queued for a valid/ready consumer.
// Define ISI_AVG_EN to add the smoothed-interval output isi_avg.
module spike_isi_decoder
  import spike_codec_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_ISI    = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          spike_in,
  output logic [CNT_W-1:0]              isi_data,
  output logic                          isi_valid,
  input  logic                          isi_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          timeout
`ifdef ISI_AVG_EN
  ,
  output logic [CNT_W-1:0]              isi_avg
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_ISI);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  isi_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_push_data, w_head;
  logic             r_spike_d, r_push, r_timeout, r_overflow;
  logic             w_event, w_push, w_timeout, w_full, w_empty, w_pop;

  assign w_event = spike_in & ~r_spike_d;
  assign w_pop   = ~w_empty & isi_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_timeout   = 1'b0;
    if (!enable) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event) begin
            w_state_nxt = MEASURE;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        MEASURE: begin
          if (w_event && (r_cnt >= CNT_MIN)) begin
            w_push    = 1'b1;
            w_cnt_nxt = CNT_ONE;
          end else if (r_cnt == CNT_MAX - CNT_ONE) begin
            // timeout is high during the cycle the counter sits at all-ones
            w_cnt_nxt   = CNT_MAX;
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // The push is registered so the entry appears one edge after the event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_spike_d   <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_spike_d <= spike_in;
      r_push    <= w_push;
      r_timeout <= w_timeout;
      if (w_push) r_push_data <= r_cnt;
      if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  isi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_push),
    .i_push_data (r_push_data),
    .i_pop       (isi_ready),
    .o_pop_data  (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (fifo_count)
  );

  assign isi_data  = w_head;
  assign isi_valid = ~w_empty;
  assign overflow  = r_overflow;
  assign timeout   = r_timeout;

`ifdef ISI_AVG_EN
  logic [CNT_W-1:0]        r_avg, w_step, w_sum;
  logic                    r_avg_init;
  logic signed [CNT_W:0]   w_diff;

  always_comb begin
    w_diff = $signed({1'b0, r_push_data}) - $signed({1'b0, r_avg});
    w_step = CNT_W'(w_diff >>> 3);
    w_sum  = r_avg + w_step;
  end

  // Every push attempt updates the average, including ones the FIFO drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_avg      <= '0;
      r_avg_init <= 1'b0;
    end else if (r_push) begin
      r_avg      <= r_avg_init ? w_sum : r_push_data;
      r_avg_init <= 1'b1;
    end
  end

  assign isi_avg = r_avg;
`endif

endmodule

// File: doc/spike_isi_decoder.md
Name: spike_isi_decoder

Overview:
Receive-side companion to the fixed-point Izhikevich neuron: consumes the neuron's spike output and decodes it into inter-spike intervals (ISI) measured in clk cycles. Each measured ISI is queued in a small FIFO and drained over a valid/ready handshake to downstream heart-rate or rhythm logic. Handles refractory filtering, counter saturation (timeout), FIFO overflow, and enable gating.

Parameters:
CNT_W, 16, width of the ISI counter and of isi_data
FIFO_DEPTH, 4, number of ISI entries buffered (power of two, >=2)
MIN_ISI, 2, edges arriving with running count < MIN_ISI are ignored as glitches

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
enable  in  1  measurement enable; low forces IDLE and holds the counter, while the FIFO still drains
spike_in  in  1  spike level from the neuron
isi_data  out  CNT_W  head-of-FIFO interval, in cycles
isi_valid  out  1  FIFO not empty
isi_ready  in  1  consumer accepts isi_data when isi_valid & isi_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky; set when an ISI is dropped because the FIFO is full
timeout  out  1  one-cycle pulse when the counter saturates
isi_avg  out  CNT_W  smoothed ISI (present only with ISI_AVG_EN)

Behaviour:
- Reset is asynchronous and active-high. Reset clears: state=IDLE, cnt=0, spike_d=0, FIFO empty, isi_valid=0, isi_data=0, fifo_count=0, overflow=0, timeout=0, isi_avg=0.
- Event detection: event = spike_in & ~spike_d, with spike_d registered every cycle. Multi-cycle spike levels therefore yield exactly one event.
- States: IDLE and MEASURE.
  - IDLE + event + enable -> MEASURE. Set cnt=1. Nothing is pushed.
  - MEASURE, no event: cnt increments by 1 per cycle.
  - MEASURE, event with cnt >= MIN_ISI: push cnt into the FIFO and reload cnt=1. The pushed value equals t1 - t0, the number of cycles between the two event cycles.
  - MEASURE, event with cnt < MIN_ISI: ignore it; cnt keeps counting.
  - MEASURE, cnt reaches 2^CNT_W-1: timeout=1 for that cycle, state -> IDLE, nothing is pushed. The next event restarts measurement.
  - enable=0 from any state: state -> IDLE at the next edge. cnt holds its value and is discarded on restart.
- Latency: an event sampled at edge k makes the entry visible (isi_valid=1 if the FIFO was empty) after edge k+1.
- FIFO handshake:
  - Pop occurs when isi_valid & isi_ready.
  - isi_data is stable while isi_valid=1 and no pop occurs.
  - isi_ready while empty has no effect.
- Push when full:
  - If a pop occurs in the same cycle, the push is accepted (count unchanged).
  - Otherwise the push is dropped, overflow is set, and it stays set until reset.
- Push and pop on a non-full, non-empty FIFO in the same cycle: count unchanged, order preserved (FIFO order).
- Read and write pointers wrap modulo FIFO_DEPTH.
- Reset mid-measurement or mid-drain discards all state immediately.
- All ISI arithmetic is unsigned CNT_W. No fixed-point conversion happens in this block.

Optional Feature:
Macro ISI_AVG_EN.
- Defined: isi_avg port exists.
  - On the first accepted push after reset, isi_avg loads the ISI directly.
  - On each later push, isi_avg <= isi_avg + ((isi - isi_avg) >>> 3), computed in signed CNT_W+1 and truncated to CNT_W. The shift is an arithmetic right shift of the signed difference.
  - Dropped (overflow) pushes still update isi_avg.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package spike_codec_pkg holds:
  - the state enum (IDLE, MEASURE)
  - the default CNT_W
  - the Q4.16 format constants shared with the neuron (20-bit signed, 16 fractional bits)
- Sub-module isi_fifo: parameterised synchronous FIFO (DEPTH, WIDTH) with push/pop/full/empty/count.
- The top level holds edge detect, the FSM/counter and the optional average.

Test Plan:
- Reset, then spike_in pulses at cycles 10, 60, 160 with isi_ready=1 -> isi_data 50 then 100, each with isi_valid for exactly one cycle, visible 1 cycle after the event edge.
- spike_in held high for 5 cycles at cycles 10 and 40 -> a single entry of 30 (one event per level).
- Events at 10, 11, 30 with MIN_ISI=2 -> the event at 11 is ignored; the entry is 20.
- isi_ready=0, six ISIs of 10 -> fifo_count=4, overflow=1, and the drained values are the first four, in order.
- CNT_W=8, event at cycle 0, no further spikes -> timeout pulses when cnt=255 and state returns to IDLE; the next two events 20 apart give one entry of 20.
- ISI_AVG_EN defined, ISIs 80 then 160 -> isi_avg 80, then 90.
